ssm4_iter_unit: RTL

//  Sequential SM4 functional unit for the scarv-cpu execute stage.
//  - Computes scalar ssm4.ed / ssm4.ks for XLEN=32 or 64.
//  - Optionally computes a full-word T-transform ("round") mode: all four
//    S-box bytes and the L / L' linear layer, over several cycles.
//  - S-box lanes are reused across cycles.
//  - Requests use a valid/ready handshake from decode; responses use a

---
 rtl/ssm4_iter_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ssm4_iter_unit.sv
// Iterative SM4 ssm4.ed/ssm4.ks unit; SSM4_ROUND_EN adds a full-word T-transform (round) mode.
// Latency: 1 cycle from acceptance for single-byte ops and traps, 4/LANES cycles for round ops.
// Backpressure: result held in DONE while rsp_ready is low; req_ready only in IDLE, or in DONE when rsp_ready is high.
module ssm4_iter_unit #(
  parameter int XLEN  = 32,
  parameter int LANES = 1
) (
  input  logic            g_clk,
  input  logic            g_rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_ed,
  input  logic            req_ks,
  input  logic            req_round,
  input  logic [1:0]      req_bs,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rd,
  output logic            rsp_trap
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("ssm4_iter_unit: XLEN must be 32 or 64");
  end
`ifdef SSM4_ROUND_EN
  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("ssm4_iter_unit: LANES must be 1, 2 or 4");
  end
`else
  if (LANES != 1) begin : g_bad_lanes
    $error("ssm4_iter_unit: LANES must be 1 without round mode");
  end
`endif

  localparam logic [0:255][7:0] SBOX = {
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [31:0] lin(input logic ks, input logic [7:0] s);
    logic [31:0] x;
    x = {24'd0, s};
    if (ks)
      lin = x ^ ((x & 32'h07) << 29) ^ ((x & 32'hFE) << 7) ^ ((x & 32'h01) << 23) ^ ((x & 32'hF8) << 13);
    else
      lin = x ^ (x << 8) ^ (x << 2) ^ (x << 18) ^ ((x & 32'h3F) << 26) ^ ((x & 32'hC0) << 10);
  endfunction

  function automatic logic [31:0] rotl_b(input logic [31:0] w, input logic [1:0] n);
    case (n)
      2'd0:    rotl_b = w;
      2'd1:    rotl_b = {w[23:0], w[31:24]};
      2'd2:    rotl_b = {w[15:0], w[31:16]};
      default: rotl_b = {w[7:0],  w[31:8]};
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] rs1_q, rs2_q;
  logic        ks_q, trap_q;
  logic [1:0]  bs_q;
  logic        accept, last;
  logic        req_trap;
  logic [31:0] acc_d, rd32;
  logic [1:0]  idx;
  logic [XLEN-1:0] rd_ext;

  assign req_ready = !g_rst && (state_q == IDLE || (state_q == DONE && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == DONE);

`ifdef SSM4_ROUND_EN
  logic        round_q;
  logic [2:0]  cnt_q;
  logic [31:0] acc_q;
  assign req_trap = (req_ed == req_ks);

  // Single-byte ops use lane 0 only; round ops sweep bytes cnt..cnt+LANES-1.
  always_comb begin
    acc_d = acc_q;
    idx   = bs_q;
    for (int l = 0; l < LANES; l++) begin
      idx = round_q ? (cnt_q[1:0] + 2'(l)) : bs_q;
      if (round_q || l == 0)
        acc_d = acc_d ^ rotl_b(lin(ks_q, SBOX[rs2_q[8*idx +: 8]]), idx);
    end
    last = round_q ? ((cnt_q + 3'(LANES)) == 3'd4) : 1'b1;
  end
`else
  assign req_trap = (req_ed == req_ks) || req_round;

  always_comb begin
    idx   = bs_q;
    acc_d = rotl_b(lin(ks_q, SBOX[rs2_q[8*idx +: 8]]), idx);
    last  = 1'b1;
  end
`endif

  assign rd32 = rs1_q ^ acc_d;

  if (XLEN == 64) begin : g_x64
    logic unused_hi;
    assign unused_hi = ^{req_rs1[XLEN-1:32], req_rs2[XLEN-1:32]};
    assign rd_ext    = {{32{rd32[31]}}, rd32};
  end else begin : g_x32
    assign rd_ext = rd32;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (rsp_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state_q  <= IDLE;
      rs1_q    <= '0;
      rs2_q    <= '0;
      ks_q     <= 1'b0;
      trap_q   <= 1'b0;
      bs_q     <= 2'd0;
      rsp_rd   <= '0;
      rsp_trap <= 1'b0;
`ifdef SSM4_ROUND_EN
      round_q  <= 1'b0;
      cnt_q    <= 3'd0;
      acc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        rs1_q  <= req_rs1[31:0];
        rs2_q  <= req_rs2[31:0];
        ks_q   <= req_ks;
        trap_q <= req_trap;
        bs_q   <= req_bs;
`ifdef SSM4_ROUND_EN
        // A trapping round request completes with single-byte latency.
        round_q <= req_round && !req_trap;
        cnt_q   <= 3'd0;
        acc_q   <= '0;
`endif
      end
      if (state_q == BUSY) begin
`ifdef SSM4_ROUND_EN
        acc_q <= acc_d;
        cnt_q <= cnt_q + 3'(LANES);
`endif
        if (last) begin
          rsp_rd   <= trap_q ? '0 : rd_ext;
          rsp_trap <= trap_q;
        end
      end
    end
  end

endmodule
